demod_lo_ctrl: RTL and testbench

- Sequencer for the IF-to-baseband IQ demodulator.
- Generates the fs/4 quadrature LO codes (cosine_out/sine_out) that drive the demodulator multipliers, one LO step per accepted ADC sample.
- Generates demod_rdy aligned to the cycle in which I_BB/Q_BB are valid.
- Runs fixed-length bursts or continuous capture under start/stop control, counts samples and flags ADC-rate violations.

---
 rtl/demod_lo_ctrl.sv | 121 ++++++++++++
 tb/tb_demod_lo_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demod_lo_ctrl.sv
// rtl/demod_lo_ctrl.sv - fs/4 quadrature LO sequencer and capture control for the IQ demodulator
module demod_lo_ctrl #(
    parameter int CNT_W   = 16,
    parameter int MIN_GAP = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             lo_dir,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             ADC_rdy,
    output logic [1:0]       cosine_out,
    output logic [1:0]       sine_out,
    output logic             demod_rdy,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             overrun
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state;
    logic [1:0]       phase;
    logic             dir_q;
    logic [CNT_W-1:0] len_q;
    logic [GAP_W-1:0] gap;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             last_sample;

    // Returns {cos, sin}; lo_dir=1 negates sine to flip the rotation direction.
    function automatic logic [3:0] lo_code(input logic [1:0] p, input logic dir);
        logic [3:0] code;
        case (p)
            2'd0:    code = {2'b01, 2'b00};
            2'd1:    code = {2'b00, (dir ? 2'b11 : 2'b01)};
            2'd2:    code = {2'b11, 2'b00};
            default: code = {2'b00, (dir ? 2'b01 : 2'b11)};
        endcase
        return code;
    endfunction

    assign cnt_next    = sample_cnt + 1'b1;
    assign accept      = (state == S_RUN) && ADC_rdy && (gap == '0);
    assign last_sample = accept && (len_q != '0) && (cnt_next == len_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            phase      <= 2'd3;
            dir_q      <= 1'b0;
            len_q      <= '0;
            gap        <= '0;
            cosine_out <= 2'b00;
            sine_out   <= 2'b00;
            demod_rdy  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
        end else begin
            demod_rdy <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !stop) begin
                        state                  <= S_RUN;
                        phase                  <= 2'd3;
                        sample_cnt             <= '0;
                        overrun                <= 1'b0;
                        dir_q                  <= lo_dir;
                        len_q                  <= burst_len;
                        gap                    <= '0;
                        busy                   <= 1'b1;
                        {cosine_out, sine_out} <= lo_code(2'd3, lo_dir);
                    end
                end
                S_RUN: begin
                    // Sample is presented with its LO one cycle after the accepted strobe.
                    if (accept) begin
                        phase                  <= phase + 2'd1;
                        sample_cnt             <= cnt_next;
                        gap                    <= GAP_W'(MIN_GAP - 1);
                        demod_rdy              <= 1'b1;
                        {cosine_out, sine_out} <= lo_code(phase + 2'd1, dir_q);
                    end else begin
                        if (ADC_rdy) begin
                            overrun <= 1'b1;
                        end
                        if (gap != '0) begin
                            gap <= gap - 1'b1;
                        end
                    end
                    if (stop || last_sample) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state      <= S_DONE;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    cosine_out <= 2'b00;
                    sine_out   <= 2'b00;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demod_lo_ctrl.sv
// tb/tb_demod_lo_ctrl.sv - self-checking bench for demod_lo_ctrl
module tb_demod_lo_ctrl;

    localparam int CNT_W   = 16;
    localparam int MIN_GAP = 2;

    logic             clk;
    logic             resetn;
    logic             start;
    logic             stop;
    logic             lo_dir;
    logic [CNT_W-1:0] burst_len;
    logic             adc_rdy;
    logic [1:0]       cosine_out;
    logic [1:0]       sine_out;
    logic             demod_rdy;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic             overrun;

    demod_lo_ctrl #(.CNT_W(CNT_W), .MIN_GAP(MIN_GAP)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .stop       (stop),
        .lo_dir     (lo_dir),
        .burst_len  (burst_len),
        .ADC_rdy    (adc_rdy),
        .cosine_out (cosine_out),
        .sine_out   (sine_out),
        .demod_rdy  (demod_rdy),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a capture is "running" until an end decision, after which
    // a two-cycle tail (flush, done) follows; spacing is judged by cycle distance.
    int               m_cyc;
    bit               m_run;
    int               m_tail;
    int               m_last;
    logic [CNT_W-1:0] m_cnt;
    logic [CNT_W-1:0] m_len;
    bit               m_dir;
    bit               m_ovr;
    logic [1:0]       e_cos, e_sin;
    bit               e_rdy, e_busy, e_done;

    function automatic logic [1:0] enc(input int v);
        return v[1:0];
    endfunction

    task automatic set_lo(input int k, input bit dir);
        int cos_tab[4] = '{1, 0, -1, 0};
        int sin_tab[4] = '{0, 1, 0, -1};
        e_cos = enc(cos_tab[k]);
        e_sin = enc(dir ? -sin_tab[k] : sin_tab[k]);
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_tail = 0;
        m_cnt  = '0;
        m_len  = '0;
        m_dir  = 0;
        m_ovr  = 0;
        e_cos  = 2'b00;
        e_sin  = 2'b00;
        e_rdy  = 0;
        e_busy = 0;
        e_done = 0;
    endtask

    task automatic model_step(input bit s, input bit st, input bit a, input bit d,
                              input logic [CNT_W-1:0] l);
        bit acc;
        e_rdy  = 0;
        e_done = 0;
        if (m_tail == 1) begin
            m_tail = 2;
            e_done = 1;
            e_cos  = 2'b00;
            e_sin  = 2'b00;
        end else if (m_tail == 2) begin
            m_tail = 0;
        end else if (!m_run) begin
            if (s && !st) begin
                m_run  = 1;
                m_cnt  = '0;
                m_ovr  = 0;
                m_dir  = d;
                m_len  = l;
                m_last = m_cyc - MIN_GAP;
                set_lo(3, d);
            end
        end else begin
            acc = a && (m_cyc - m_last >= MIN_GAP);
            if (acc) begin
                m_cnt  = m_cnt + 1'b1;
                m_last = m_cyc;
                e_rdy  = 1;
                set_lo((int'(m_cnt) + 3) % 4, m_dir);
            end else if (a) begin
                m_ovr = 1;
            end
            if (st || (acc && m_len != 0 && m_cnt == m_len)) begin
                m_run  = 0;
                m_tail = 1;
            end
        end
        e_busy = m_run || (m_tail == 1);
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, m_cyc, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cos"},     32'(cosine_out), 32'(e_cos));
        chk({tag, ".sin"},     32'(sine_out),   32'(e_sin));
        chk({tag, ".rdy"},     32'(demod_rdy),  32'(e_rdy));
        chk({tag, ".busy"},    32'(busy),       32'(e_busy));
        chk({tag, ".done"},    32'(done),       32'(e_done));
        chk({tag, ".cnt"},     32'(sample_cnt), 32'(m_cnt));
        chk({tag, ".overrun"}, 32'(overrun),    32'(m_ovr));
    endtask

    task automatic step(input string tag, input bit s, input bit st, input bit a,
                        input bit d, input logic [CNT_W-1:0] l);
        @(negedge clk);
        start = s; stop = st; adc_rdy = a; lo_dir = d; burst_len = l;
        model_step(s, st, a, d, l);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, '0);
    endtask

    task automatic burst(input string tag, input logic [CNT_W-1:0] len, input bit d,
                         input int period, input int n, input bit end_with_stop);
        step(tag, 1, 0, 0, d, len);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < period; j++) step(tag, 0, 0, j == 0, 0, '0);
        if (end_with_stop) step(tag, 0, 1, 0, 0, '0);
        idle(tag, 4);
    endtask

    typedef struct {
        bit         s, st, a, d;
        logic [1:0] cos, sin;
        bit         rdy, bsy, dn;
        int         cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Start+stop together, then a stop coincident with the 3rd strobe.
        vecs[0] = '{1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0};
        vecs[1] = '{1, 0, 0, 0, 2'b00, 2'b11, 0, 1, 0, 0};
        vecs[2] = '{0, 0, 1, 0, 2'b01, 2'b00, 1, 1, 0, 1};
        vecs[3] = '{0, 0, 0, 0, 2'b01, 2'b00, 0, 1, 0, 1};
        vecs[4] = '{0, 0, 1, 0, 2'b00, 2'b01, 1, 1, 0, 2};
        vecs[5] = '{0, 0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 2};
        vecs[6] = '{0, 1, 1, 0, 2'b11, 2'b00, 1, 1, 0, 3};
        vecs[7] = '{0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 3};
        vecs[8] = '{0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 3};
        vecs[9] = '{0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 0, 3};

        start = 0; stop = 0; adc_rdy = 0; lo_dir = 0; burst_len = '0;
        resetn = 0;
        m_cyc  = 0;
        model_reset();
        #1;
        check_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1;

        for (int i = 0; i < 10; i++) begin
            step("vec", vecs[i].s, vecs[i].st, vecs[i].a, vecs[i].d, '0);
            chk($sformatf("vec%0d.cos", i),  32'(cosine_out), 32'(vecs[i].cos));
            chk($sformatf("vec%0d.sin", i),  32'(sine_out),   32'(vecs[i].sin));
            chk($sformatf("vec%0d.rdy", i),  32'(demod_rdy),  32'(vecs[i].rdy));
            chk($sformatf("vec%0d.busy", i), 32'(busy),       32'(vecs[i].bsy));
            chk($sformatf("vec%0d.done", i), 32'(done),       32'(vecs[i].dn));
            chk($sformatf("vec%0d.cnt", i),  32'(sample_cnt), 32'(vecs[i].cnt));
        end

        burst("b8", 16'd8, 0, 4, 8, 0);
        chk("b8.final_cnt", 32'(sample_cnt), 32'd8);
        burst("b4dir", 16'd4, 1, 3, 4, 0);
        burst("cont20", 16'd0, 0, 2, 20, 1);
        chk("cont20.final_cnt", 32'(sample_cnt), 32'd20);
        chk("cont20.overrun", 32'(overrun), 32'd0);

        // Back-to-back strobes: second is dropped, next spaced strobe takes p1.
        step("gap", 1, 0, 0, 0, '0);
        step("gap", 0, 0, 1, 0, '0);
        step("gap", 0, 0, 1, 0, '0);
        chk("gap.overrun", 32'(overrun), 32'd1);
        chk("gap.cnt", 32'(sample_cnt), 32'd1);
        step("gap", 0, 0, 0, 0, '0);
        step("gap", 0, 0, 1, 0, '0);
        chk("gap.p1_cos", 32'(cosine_out), 32'(2'b00));
        chk("gap.p1_sin", 32'(sine_out), 32'(2'b01));
        chk("gap.sticky", 32'(overrun), 32'd1);
        step("gap", 0, 1, 0, 0, '0);
        idle("gap", 3);

        // Reset in the middle of a 10-sample burst, then restart.
        step("rst", 1, 0, 0, 0, 16'd10);
        for (int i = 0; i < 5; i++) begin
            step("rst", 0, 0, 1, 0, '0);
            step("rst", 0, 0, 0, 0, '0);
        end
        @(negedge clk);
        #2 resetn = 0;
        #1;
        model_reset();
        check_all("rst.async");
        @(posedge clk);
        #1;
        check_all("rst.held");
        @(negedge clk);
        resetn = 1;
        idle("rst.nodone", 3);
        step("rst2", 1, 0, 0, 0, 16'd10);
        step("rst2", 0, 0, 1, 0, '0);
        chk("rst2.cnt", 32'(sample_cnt), 32'd1);
        chk("rst2.p0_cos", 32'(cosine_out), 32'(2'b01));
        step("rst2", 0, 1, 0, 0, '0);
        idle("rst2", 3);

        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom % 6) == 0, ($urandom % 40) == 0, ($urandom % 3) == 0,
                 1'($urandom), CNT_W'($urandom % 7));
        end
        idle("rand", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
